// File: rtl/f1_light_seq_pkg.sv
// ---------------------------------------------------------------------------
// f1_pkg
// Shared definitions for the F1 start-light sequencer:
//   f1_state_t : sequencer state encoding (IDLE, CYCLE, FILL, HOLD, OUT)
//   lfsr_taps  : Fibonacci feedback tap mask for a maximal-length LFSR of
//                width 4..8 (returns 0 for unsupported widths)
// ---------------------------------------------------------------------------
package f1_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CYCLE = 3'd1,
      FILL  = 3'd2,
      HOLD  = 3'd3,
      OUT   = 3'd4
   } f1_state_t;

   // Bit i of the mask set means register bit i feeds the XOR.
   // Each mask gives a primitive feedback polynomial for a left-shifting register.
   function automatic logic [7:0] lfsr_taps(input int width);
      logic [7:0] taps;
      case (width)
         4:       taps = 8'h09;
         5:       taps = 8'h12;
         6:       taps = 8'h21;
         7:       taps = 8'h41;
         8:       taps = 8'hB8;
         default: taps = 8'h00;
      endcase
      return taps;
   endfunction

endpackage

// File: rtl/f1_light_seq_lfsr.sv
// ---------------------------------------------------------------------------
// f1_lfsr
// Free-running maximal-length Fibonacci LFSR that supplies the random hold
// length for race-start mode. It steps on every clock and never holds zero.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, loads SEED
//   q     : current LFSR value, DELAY_W bits
// ---------------------------------------------------------------------------
module f1_lfsr
   import f1_pkg::*;
#(
   parameter int DELAY_W = 7,
   parameter int SEED    = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [DELAY_W-1:0] q
);

   localparam logic [DELAY_W-1:0] TAPS   = DELAY_W'(lfsr_taps(DELAY_W));
   localparam logic [DELAY_W-1:0] SEED_V = DELAY_W'(SEED);

   logic [DELAY_W-1:0] r_q;
   logic               w_feedback;

   // The XOR of the tapped bits enters at bit 0 while the register shifts
   // left; with a primitive tap set and a non-zero seed the all-zero
   // state is unreachable.
   assign w_feedback = ^(r_q & TAPS);

   // Register update: runs every cycle, independent of the sequencer state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= SEED_V;
      end else begin
         r_q <= {r_q[DELAY_W-2:0], w_feedback};
      end
   end

   assign q = r_q;

endmodule

// File: rtl/f1_light_seq.sv
// ---------------------------------------------------------------------------
// f1_light_seq
// Parametrised F1 start-light sequencer driving a WIDTH-bit light bar.
// Cycle mode repeats a fill/clear pattern; race-start mode fills on a
// trigger, holds all lights for a random number of ticks, then blanks the
// bar and pulses lights_out for one clock.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   tick       : single-cycle step strobe; all stepping happens only on ticks
//   mode       : 0 = cycle mode, 1 = race-start mode
//   trigger    : starts a race-start sequence from IDLE (level-sampled)
//   data_out   : light bar, thermometer code of the current level
//   busy       : high while a race-start sequence is in progress
//   lights_out : one-cycle pulse when the lights go out
// ---------------------------------------------------------------------------
module f1_light_seq
   import f1_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int DELAY_W = 7,
   parameter int SEED    = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             mode,
   input  logic             trigger,
   output logic [WIDTH-1:0] data_out,
   output logic             busy,
   output logic             lights_out
);

   localparam int            LW        = $clog2(WIDTH + 1);
   localparam logic [LW-1:0] LEVEL_MAX = LW'(WIDTH);

   f1_state_t          r_state;
   f1_state_t          w_stateNext;
   logic [LW-1:0]      r_level;
   logic [LW-1:0]      w_levelNext;
   logic [DELAY_W-1:0] r_holdCnt;
   logic [DELAY_W-1:0] w_holdCntNext;
   logic [DELAY_W-1:0] w_lfsr;

   f1_lfsr #(
      .DELAY_W (DELAY_W),
      .SEED    (SEED)
   ) uLfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .q     (w_lfsr)
   );

   // Next-state logic. In IDLE a plain tick in cycle mode wins, and a
   // trigger in race-start mode starts the fill without consuming the tick
   // that may arrive in the same cycle. Once FILL starts, mode and trigger
   // are ignored until the sequence returns to IDLE.
   always_comb begin
      w_stateNext   = r_state;
      w_levelNext   = r_level;
      w_holdCntNext = r_holdCnt;
      case (r_state)
         IDLE: begin
            if (!mode && tick) begin
               w_stateNext = CYCLE;
               w_levelNext = LW'(1);
            end else if (mode && trigger) begin
               w_stateNext = FILL;
               w_levelNext = '0;
            end
         end
         CYCLE: begin
            if (mode) begin
               w_stateNext = IDLE;
               w_levelNext = '0;
            end else if (tick) begin
               if (r_level == LEVEL_MAX) begin
                  w_stateNext = IDLE;
                  w_levelNext = '0;
               end else begin
                  w_levelNext = r_level + LW'(1);
               end
            end
         end
         FILL: begin
            // Level never exceeds WIDTH-1 here, so the increment cannot wrap.
            if (tick) begin
               w_levelNext = r_level + LW'(1);
               if (w_levelNext == LEVEL_MAX) begin
                  w_stateNext   = HOLD;
                  w_holdCntNext = w_lfsr;
               end
            end
         end
         HOLD: begin
            // The loaded count is the number of hold ticks still to come.
            if (tick) begin
               if (r_holdCnt == DELAY_W'(1)) begin
                  w_stateNext = OUT;
                  w_levelNext = '0;
               end else begin
                  w_holdCntNext = r_holdCnt - DELAY_W'(1);
               end
            end
         end
         OUT: begin
            w_stateNext = IDLE;
            w_levelNext = '0;
         end
         default: begin
            w_stateNext = IDLE;
            w_levelNext = '0;
         end
      endcase
   end

   // State, level and hold counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_level   <= '0;
         r_holdCnt <= '0;
      end else begin
         r_state   <= w_stateNext;
         r_level   <= w_levelNext;
         r_holdCnt <= w_holdCntNext;
      end
   end

   // Thermometer decode: bit i lights when i is below the level. Done
   // bitwise so WIDTH=32 needs no 33-bit intermediate.
   always_comb begin
      data_out = '0;
      for (int i = 0; i < WIDTH; i++) begin
         data_out[i] = (i < int'(r_level));
      end
   end

   assign busy       = (r_state == FILL) || (r_state == HOLD) || (r_state == OUT);
   assign lights_out = (r_state == OUT);

endmodule
